// File: rtl/everloop_ws2812_tx.sv
// Serial WS2812/SK6812 line driver: fetches colour bytes over a request/ack
// read port, serialises them MSB first, then holds the line low to latch.
module everloop_ws2812_tx #(
  parameter int unsigned N_BYTES   = 141,
  parameter int unsigned BIT_CYC   = 188,
  parameter int unsigned T0H_CYC   = 53,
  parameter int unsigned T1H_CYC   = 105,
  parameter int unsigned LATCH_CYC = 9000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_reset_everloop,
  output logic       o_en_rd,
  input  logic       i_ack,
  input  logic [7:0] i_data_rgb,
  output logic       o_everloop_d,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_underrun
);

  localparam int unsigned BcW = $clog2(BIT_CYC + 1);
  localparam int unsigned ByW = $clog2(N_BYTES + 1);
  localparam int unsigned LcW = $clog2(LATCH_CYC + 1);

  typedef enum logic [1:0] {StIdle, StFetch, StShift, StLatch} state_e;

  state_e         r_state;
  state_e         w_state_nxt;
  logic [BcW-1:0] r_bit_cnt;
  logic [2:0]     r_bit_idx;
  logic [ByW-1:0] r_byte_cnt;
  logic [LcW-1:0] r_latch_cnt;
  logic [7:0]     r_shift;
  logic [7:0]     r_buf;
  logic           r_buf_valid;
  logic           r_req_out;
  logic           r_stale;
  logic           r_underrun;

  logic w_ack_ok;
  logic w_bit_end;
  logic w_byte_end;
  logic w_last_byte;
  logic w_frame_end;
  logic w_latch_end;
  logic w_abort;
  logic w_stall;
  logic w_hi;
  logic w_en_rd;

  // Ack counts only for a live (non-stale) outstanding request.
  assign w_ack_ok    = i_ack && r_req_out && !r_stale;
  assign w_bit_end   = (r_state == StShift) && (r_bit_cnt == BcW'(BIT_CYC - 1));
  assign w_byte_end  = w_bit_end && (r_bit_idx == 3'd0);
  assign w_last_byte = (r_byte_cnt == ByW'(N_BYTES - 1));
  assign w_frame_end = w_byte_end && w_last_byte;
  assign w_latch_end = (r_state == StLatch) && (r_latch_cnt == LcW'(LATCH_CYC - 1));
  assign w_abort     = i_reset_everloop && (r_state != StIdle);
  // Byte boundary reached with neither a buffered nor an arriving byte.
  assign w_stall     = w_byte_end && !w_last_byte && !r_buf_valid && !w_ack_ok;
  assign w_hi        = r_bit_cnt < (r_shift[7] ? BcW'(T1H_CYC) : BcW'(T0H_CYC));
  assign o_en_rd     = w_en_rd;
  assign o_underrun  = r_underrun;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_en_rd      = 1'b0;
    o_busy       = 1'b0;
    o_everloop_d = 1'b0;
    o_frame_done = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_enable) w_state_nxt = StFetch;
      end
      StFetch: begin
        o_busy  = 1'b1;
        w_en_rd = !r_req_out;
        if (w_ack_ok) w_state_nxt = StShift;
      end
      StShift: begin
        o_busy       = 1'b1;
        o_everloop_d = w_hi;
        // Prefetch the next byte as soon as the current one starts.
        w_en_rd      = (r_bit_idx == 3'd7) && (r_bit_cnt == '0) && !w_last_byte &&
                       !r_req_out && !r_buf_valid;
        if (w_frame_end) w_state_nxt = StLatch;
      end
      StLatch: begin
        o_frame_done = w_latch_end;
        if (w_latch_end) w_state_nxt = i_enable ? StFetch : StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
    if (w_abort) w_state_nxt = StLatch;
  end

  // Request tracking, prefetch buffer, shifter, byte and latch counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_req_out   <= 1'b0;
      r_stale     <= 1'b0;
      r_underrun  <= 1'b0;
      r_buf_valid <= 1'b0;
      r_buf       <= '0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_bit_idx   <= '0;
      r_byte_cnt  <= '0;
      r_latch_cnt <= '0;
    end else begin
      // An aborted request stays outstanding but its ack will be dropped.
      if (w_abort) begin
        r_req_out <= w_en_rd || (r_req_out && !i_ack);
        r_stale   <= w_en_rd || (r_req_out && !i_ack);
      end else if (w_en_rd) begin
        r_req_out <= 1'b1;
      end else if (r_req_out && i_ack) begin
        r_req_out <= 1'b0;
        r_stale   <= 1'b0;
      end

      if (w_stall) r_underrun <= 1'b1;

      if (w_abort || w_frame_end) begin
        r_buf_valid <= 1'b0;
      end else if (w_ack_ok && (r_state == StShift) && !w_byte_end) begin
        r_buf       <= i_data_rgb;
        r_buf_valid <= 1'b1;
      end else if (w_byte_end && r_buf_valid) begin
        r_buf_valid <= 1'b0;
      end

      if ((r_state == StFetch) && w_ack_ok) begin
        r_shift   <= i_data_rgb;
        r_bit_idx <= 3'd7;
        r_bit_cnt <= '0;
      end else if (r_state == StShift) begin
        if (!w_bit_end) begin
          r_bit_cnt <= r_bit_cnt + BcW'(1);
        end else if (r_bit_idx != 3'd0) begin
          r_bit_cnt <= '0;
          r_bit_idx <= r_bit_idx - 3'd1;
          r_shift   <= {r_shift[6:0], 1'b0};
        end else if (!w_last_byte && (r_buf_valid || w_ack_ok)) begin
          // An ack landing exactly on the boundary (or ending a stall) loads directly.
          r_shift    <= r_buf_valid ? r_buf : i_data_rgb;
          r_bit_cnt  <= '0;
          r_bit_idx  <= 3'd7;
          r_byte_cnt <= r_byte_cnt + ByW'(1);
        end
      end

      if (w_abort || w_frame_end) begin
        r_byte_cnt  <= '0;
        r_latch_cnt <= '0;
      end else if (r_state == StLatch) begin
        r_latch_cnt <= r_latch_cnt + LcW'(1);
      end
    end
  end

endmodule

// File: tb/tb_everloop_ws2812_tx.sv
// Directed bench for everloop_ws2812_tx: bit timing, prefetch, underrun,
// abort and stop, with a small RAM responder on the read handshake.
module tb_everloop_ws2812_tx;

  localparam int NB          = 7;
  localparam int BIT_CYC     = 188;
  localparam int T0H         = 53;
  localparam int T1H         = 105;
  localparam int LATCH       = 9000;
  localparam int STALL_EXTRA = 400;
  // Byte 1 is requested on the first cycle of byte 0; its boundary stall starts 1503 later.
  localparam int STALL_LAT   = 8 * BIT_CYC - 1 + STALL_EXTRA;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       reset_everloop;
  logic       en_rd;
  logic       ack;
  logic [7:0] data_rgb;
  logic       everloop_d;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  logic [7:0] mem [8];
  int n_checks = 0;
  int n_pass   = 0;
  int en_cnt   = 0;
  int en_last  = 0;
  int fd_cnt   = 0;
  int frame_no = 1;

  everloop_ws2812_tx #(
    .N_BYTES  (NB),
    .BIT_CYC  (BIT_CYC),
    .T0H_CYC  (T0H),
    .T1H_CYC  (T1H),
    .LATCH_CYC(LATCH)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_enable        (enable),
    .i_reset_everloop(reset_everloop),
    .o_en_rd         (en_rd),
    .i_ack           (ack),
    .i_data_rgb      (data_rgb),
    .o_everloop_d    (everloop_d),
    .o_busy          (busy),
    .o_frame_done    (frame_done),
    .o_underrun      (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // Count requests per frame and frame_done cycles.
  always @(negedge clk) begin
    if (en_rd === 1'b1) en_cnt++;
    if (frame_done === 1'b1) begin
      fd_cnt++;
      en_last = en_cnt;
      en_cnt  = 0;
    end
  end

  // RAM: acks each request after a frame-dependent latency, bytes in address order.
  initial begin
    int cd;
    int idx;
    int lat;
    cd = 0;
    idx = 0;
    ack = 1'b0;
    data_rgb = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      ack = 1'b0;
      if (frame_done === 1'b1) begin
        idx = 0;
        frame_no++;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          ack = 1'b1;
          data_rgb = mem[idx % 8];
          idx++;
        end
      end
      if (en_rd === 1'b1) begin
        lat = (frame_no == 1) ? 2 : 20;
        if (frame_no == 3 && idx == 1) lat = STALL_LAT;
        if (frame_no == 3 && idx == 6) lat = 600;
        cd = lat;
      end
    end
  end

  initial begin
    #(2000000);
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass,
             n_checks);
    $fatal(1);
  end

  // Enter at the first high sample of a bit; leave at the next rise or at lim low samples.
  task automatic measure_bit(input int lim, output int hi, output int lo);
    hi = 0;
    lo = 0;
    while (everloop_d && hi < 400) begin
      hi++;
      @(negedge clk);
    end
    while (!everloop_d && lo < lim) begin
      lo++;
      @(negedge clk);
    end
  endtask

  // Walk one frame bit by bit, starting at the first rise of byte 0.
  task automatic run_frame(input int next_lat, input int stall_byte, input int abort_byte,
                           input bit stop);
    int hi, lo, exp_hi, exp_lo, lim;
    logic [7:0] byt;
    bit last;
    for (int b = 0; b < NB; b++) begin
      byt = mem[b];
      for (int i = 7; i >= 0; i--) begin
        if (stall_byte >= 0 && i == 7 && b == stall_byte) check("underrun_before", underrun, 0);
        if (stall_byte >= 0 && i == 7 && b == stall_byte + 1) check("underrun_set", underrun, 1);
        if (b == abort_byte && i == 6) begin
          repeat (60) @(negedge clk);
          reset_everloop = 1'b1;
          @(negedge clk);
          reset_everloop = 1'b0;
          check("abort_line_low", everloop_d, 0);
          check("abort_busy", busy, 0);
          lo = 0;
          while (!everloop_d && lo < 12000) begin
            lo++;
            @(negedge clk);
          end
          check("abort_latch_low", lo, LATCH + 1 + next_lat);
          return;
        end
        if (stop && b == 2 && i == 7) enable = 1'b0;
        last   = (b == NB - 1) && (i == 0);
        exp_hi = byt[i] ? T1H : T0H;
        exp_lo = BIT_CYC - exp_hi;
        if (b == stall_byte && i == 0) exp_lo += STALL_EXTRA;
        if (last) exp_lo += stop ? LATCH + 30 : LATCH + 1 + next_lat;
        lim = (stop && last) ? exp_lo : exp_lo + 50;
        measure_bit(lim, hi, lo);
        check($sformatf("byte%0d_bit%0d_high", b, i), hi, exp_hi);
        check($sformatf("byte%0d_bit%0d_low", b, i), lo, exp_lo);
      end
    end
  endtask

  initial begin
    int cnt;
    mem[0] = 8'hA5; mem[1] = 8'h00; mem[2] = 8'h3C; mem[3] = 8'hFF;
    mem[4] = 8'h81; mem[5] = 8'hC3; mem[6] = 8'h5A; mem[7] = 8'h77;
    rst = 1'b1;
    enable = 1'b0;
    reset_everloop = 1'b0;

    // Reset and idle with enable low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", int'({en_rd, everloop_d, busy, frame_done, underrun}), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("idle_no_en_rd", en_cnt, 0);
    check("idle_busy", busy, 0);
    check("idle_line", everloop_d, 0);

    // Frame 1: ack latency 2, bit timing and latch.
    @(negedge clk);
    enable = 1'b1;
    cnt = 0;
    while (!everloop_d && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("first_rise_latency", cnt, 4);
    check("first_busy", busy, 1);
    run_frame(20, -1, -1, 1'b0);
    check("f1_frame_done", fd_cnt, 1);
    check("f1_en_rd", en_last, NB);
    check("f1_underrun", underrun, 0);

    // Frame 2: ack latency 20, prefetch keeps bits back to back.
    run_frame(20, -1, -1, 1'b0);
    check("f2_frame_done", fd_cnt, 2);
    check("f2_en_rd", en_last, NB);
    check("f2_underrun", underrun, 0);

    // Frame 3: byte 1 stalls 400 cycles, then abort in byte 5 with a request outstanding.
    run_frame(20, 0, 5, 1'b0);
    check("f3_frame_done", fd_cnt, 3);
    check("f3_en_rd", en_last, NB);
    check("f3_underrun_sticky", underrun, 1);

    // Frame 4: restarts at byte 0; enable drops mid-frame, frame completes then idles.
    run_frame(20, -1, -1, 1'b1);
    #1;
    check("f4_frame_done", fd_cnt, 4);
    check("f4_en_rd", en_last, NB);
    check("f4_busy", busy, 0);
    repeat (300) @(negedge clk);
    #1;
    check("stop_no_en_rd", en_cnt, 0);
    check("stop_line", everloop_d, 0);
    check("stop_busy", busy, 0);
    check("stop_frame_done", fd_cnt, 4);
    check("stop_underrun_sticky", underrun, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
